decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode/operand stage directly upstream of the ALU. Holds the 32-entry integer
//  register file, extracts opcode/funct3/funct7/rd, and builds the ALU operands:
//  rs1 value and the second operand (rs2 value for R-type, sign-extended imm for I-type).
//  Results sit in an ID/EX pipeline register with a valid/ready handshake toward execute.
// PARAMETERS
//  DATA_W      32  operand/register width
//  REG_ADDR_W  5   register index width (2**REG_ADDR_W registers)
// PORTS
//  clk_in          in   1       rising-edge clock
//  rst_in          in   1       asynchronous, active-high reset
//  instr_valid_in  in   1       instr_in holds a valid instruction
//  instr_in        in   32      RV32I instruction word
//  instr_ready_out out  1       stage accepts an instruction this cycle
//  wb_en_in        in   1       writeback enable from the writeback stage
//  wb_rd_in        in   5       writeback destination register
//  wb_data_in      in   32      writeback data
//  ex_ready_in     in   1       execute consumes the ID/EX contents this cycle
//  ex_valid_out    out  1       ID/EX register holds a valid decoded instruction
//  opcode_out      out  7       instr[6:0]   -> ALU opcode_in
//  funct3_out      out  3       instr[14:12] -> ALU funct3_in
//  funct7_out      out  7       instr[31:25] -> ALU funct7_in
//  rs1_value_out   out  32      value of x[rs1] -> ALU rs1_value_in
//  mux_result_out  out  32      second operand  -> ALU mux_result_in
//  rd_out          out  5       destination register, carried to writeback
//  illegal_out     out  1       opcode not 0110011/0010011 (registered with instr)
// BEHAVIOUR
//  Reset (async, any time): ex_valid_out=0; all ID/EX outputs=0; x1..x31=0.
//   Reset mid-transfer drops the in-flight instruction; no writeback is performed.
//  Register file: x0 reads 0 always; writes to x0 ignored. Write on rising edge when
//   wb_en_in=1 and wb_rd_in!=0. Reads combinational from instr_in[19:15]/[24:20].
//  Write-through bypass: if wb_en_in=1, wb_rd_in!=0 and wb_rd_in equals a read index
//   in the same cycle, the read returns wb_data_in (not the old value).
//  Handshake: instr_ready_out = !ex_valid_out || ex_ready_in (combinational).
//   Accept = instr_valid_in && instr_ready_out -> ID/EX loads on next edge, ex_valid_out=1.
//   No accept and ex_ready_in=1 -> ex_valid_out=0 next edge.
//   ex_valid_out=1 and ex_ready_in=0 -> all ID/EX outputs hold stable (stall).
//   Accept and drain in the same cycle -> back-to-back, ex_valid_out stays 1.
//  Latency: 1 cycle instr_in -> ID/EX outputs; throughput 1 instr/cycle when unstalled.
//  Operand mux (computed at accept, registered):
//   0110011 R-type: mux_result = x[rs2]; illegal=0.
//   0010011 I-type: mux_result = {{20{instr[31]}}, instr[31:20]}; illegal=0.
//    (shift-immediates use the same extension; ALU uses low 5 bits / funct7.)
//   other opcodes: mux_result = 0, illegal=1; instruction still passes with valid=1.
//  rs1_value = x[rs1] for every opcode. rd_out = instr[11:7].
//  Writeback is independent of the handshake: writes occur even while stalled.
//   Stalled ID/EX contents are NOT refreshed by later writebacks (read at accept only).
//  instr_in ignored when instr_valid_in=0; ID/EX contents then retain last values.
// TESTING
//  1 Reset asserted mid-stream, no clock edge -> ex_valid_out=0, outputs 0 immediately;
//    after release, read of x5 returns 0.
//  2 instr 0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle opcode=0x13, funct3=0,
//    rs1_value=0, mux_result=0x00000005, rd=1, illegal=0, ex_valid=1.
//  3 wb x2=0x00001234 one cycle, then 0xFFF14193 (xori x3,x2,-1) -> rs1_value=0x1234,
//    mux_result=0xFFFFFFFF, funct3=4, rd=3.
//  4 Same-cycle bypass: wb x1=0xA, x2=0xB while presenting 0x00208233 (add x4,x1,x2)
//    -> rs1_value=0xA, mux_result=0xB, opcode=0x33, funct7=0; wb to x0 -> x0 still reads 0.
//  5 Stall: ex_ready=0 for 3 cycles with new instrs valid -> instr_ready=0, outputs frozen;
//    ex_ready=1 -> next instr loads, no instruction lost or duplicated (scoreboard order).
//  6 instr 0x00000037 (LUI) -> illegal=1, mux_result=0, ex_valid=1.

Source files
------------

// File: rtl/decode_stage.sv
// Decode/operand stage feeding the ALU: register file with write-through bypass,
// RV32I field extraction, operand mux and a valid/ready ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  instr_valid_in,
    input  logic [31:0]           instr_in,
    output logic                  instr_ready_out,
    input  logic                  wb_en_in,
    input  logic [REG_ADDR_W-1:0] wb_rd_in,
    input  logic [DATA_W-1:0]     wb_data_in,
    input  logic                  ex_ready_in,
    output logic                  ex_valid_out,
    output logic [6:0]            opcode_out,
    output logic [2:0]            funct3_out,
    output logic [6:0]            funct7_out,
    output logic [DATA_W-1:0]     rs1_value_out,
    output logic [DATA_W-1:0]     mux_result_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  illegal_out
);

    localparam int         NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
    logic [DATA_W-1:0]     rs1_val, rs2_val;
    logic                  wb_active;
    logic                  accept;

    logic                  valid_q, valid_d;
    logic [6:0]            opcode_q, funct7_q;
    logic [2:0]            funct3_q;
    logic [DATA_W-1:0]     rs1_value_q, mux_result_q, mux_result_d;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  illegal_q, illegal_d;

    assign rs1_idx   = instr_in[15 +: REG_ADDR_W];
    assign rs2_idx   = instr_in[20 +: REG_ADDR_W];
    assign wb_active = wb_en_in && (wb_rd_in != '0);

    // NOTE: the register array is cleared on reset because x1..x31 must read 0
    // afterwards; a memory without reset would map to cheaper RAM but hold stale data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_active) begin
            // NOTE: non-blocking assignment for every sequential update, so all
            // flops sample pre-edge values regardless of statement order.
            regs_q[wb_rd_in] <= wb_data_in;
        end
    end

    // x0 is hardwired to zero; a same-cycle writeback wins over the stored value.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_idx != '0)
            rs1_val = (wb_active && wb_rd_in == rs1_idx) ? wb_data_in : regs_q[rs1_idx];
        if (rs2_idx != '0)
            rs2_val = (wb_active && wb_rd_in == rs2_idx) ? wb_data_in : regs_q[rs2_idx];
    end

    always_comb begin
        mux_result_d = '0;
        illegal_d    = 1'b1;
        case (instr_in[6:0])
            OP_R: begin
                mux_result_d = rs2_val;
                illegal_d    = 1'b0;
            end
            OP_I: begin
                mux_result_d = {{(DATA_W-12){instr_in[31]}}, instr_in[31:20]};
                illegal_d    = 1'b0;
            end
            default: ;
        endcase
    end

    assign instr_ready_out = !valid_q || ex_ready_in;
    assign accept          = instr_valid_in && instr_ready_out;

    always_comb begin
        valid_d = valid_q;
        if (accept)
            valid_d = 1'b1;
        else if (ex_ready_in)
            valid_d = 1'b0;
    end

    // Payload loads only on accept, so a stall or idle cycle keeps it frozen.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q      <= 1'b0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            rs1_value_q  <= '0;
            mux_result_q <= '0;
            rd_q         <= '0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                opcode_q     <= instr_in[6:0];
                funct3_q     <= instr_in[14:12];
                funct7_q     <= instr_in[31:25];
                rs1_value_q  <= rs1_val;
                mux_result_q <= mux_result_d;
                rd_q         <= instr_in[7 +: REG_ADDR_W];
                illegal_q    <= illegal_d;
            end
        end
    end

    assign ex_valid_out   = valid_q;
    assign opcode_out     = opcode_q;
    assign funct3_out     = funct3_q;
    assign funct7_out     = funct7_q;
    assign rs1_value_out  = rs1_value_q;
    assign mux_result_out = mux_result_q;
    assign rd_out         = rd_q;
    assign illegal_out    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of single-instruction vectors, then
// stall/stream ordering and asynchronous-reset sequences.
module tb_decode_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic        instr_ready_out;
    logic        wb_en_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_data_in;
    logic        ex_ready_in;
    logic        ex_valid_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [31:0] rs1_value_out;
    logic [31:0] mux_result_out;
    logic [4:0]  rd_out;
    logic        illegal_out;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .instr_ready_out (instr_ready_out),
        .wb_en_in        (wb_en_in),
        .wb_rd_in        (wb_rd_in),
        .wb_data_in      (wb_data_in),
        .ex_ready_in     (ex_ready_in),
        .ex_valid_out    (ex_valid_out),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_out      (funct7_out),
        .rs1_value_out   (rs1_value_out),
        .mux_result_out  (mux_result_out),
        .rd_out          (rd_out),
        .illegal_out     (illegal_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] rs1_value;
        logic [31:0] mux_result;
        logic [4:0]  rd;
        logic        illegal;
    } vec_t;

    localparam int NUM_VECS   = 11;
    localparam int NUM_STREAM = 6;

    vec_t vecs [NUM_VECS];

    // addi x(k+8), x0, 0x100+k
    function automatic logic [31:0] stream_instr(input int k);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'h100 + k[11:0];
        rd  = 5'd8 + k[4:0];
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    initial begin
        logic [36:0] sb [$];
        logic [15:0] rdy_pat;
        logic        rdy, exp_valid, acc, done;
        int          sent;

        rst_in         = 1'b1;
        instr_valid_in = 1'b0;
        instr_in       = '0;
        wb_en_in       = 1'b0;
        wb_rd_in       = '0;
        wb_data_in     = '0;
        ex_ready_in    = 1'b1;

        //          wb_en wb_rd wb_data       instr         op     f3    f7     rs1           mux           rd     ill
        vecs[0]  = '{1'b0, 5'd0, 32'h0,       32'h00500093, 7'h13, 3'd0, 7'h00, 32'h0,        32'h5,        5'd1,  1'b0};
        vecs[1]  = '{1'b1, 5'd2, 32'h1234,    32'h00000013, 7'h13, 3'd0, 7'h00, 32'h0,        32'h0,        5'd0,  1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,       32'hFFF14193, 7'h13, 3'd4, 7'h7F, 32'h1234,     32'hFFFFFFFF, 5'd3,  1'b0};
        vecs[3]  = '{1'b1, 5'd1, 32'hA,       32'h00000013, 7'h13, 3'd0, 7'h00, 32'h0,        32'h0,        5'd0,  1'b0};
        vecs[4]  = '{1'b1, 5'd2, 32'hB,       32'h00208233, 7'h33, 3'd0, 7'h00, 32'hA,        32'hB,        5'd4,  1'b0};
        vecs[5]  = '{1'b1, 5'd1, 32'h55,      32'h00208233, 7'h33, 3'd0, 7'h00, 32'h55,       32'hB,        5'd4,  1'b0};
        vecs[6]  = '{1'b1, 5'd0, 32'hDEAD,    32'h000002B3, 7'h33, 3'd0, 7'h00, 32'h0,        32'h0,        5'd5,  1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,       32'h00000037, 7'h37, 3'd0, 7'h00, 32'h0,        32'h0,        5'd0,  1'b1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,       32'h00008137, 7'h37, 3'd0, 7'h00, 32'h55,       32'h0,        5'd2,  1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,       32'h7FF08F93, 7'h13, 3'd0, 7'h3F, 32'h55,       32'h7FF,      5'd31, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,       32'h40110333, 7'h33, 3'd0, 7'h20, 32'hB,        32'h55,       5'd6,  1'b0};

        #1;
        check("reset ex_valid", {31'd0, ex_valid_out}, 32'd0);
        check("reset rs1_value", rs1_value_out, 32'd0);
        check("reset mux_result", mux_result_out, 32'd0);
        check("reset instr_ready", {31'd0, instr_ready_out}, 32'd1);
        #11;
        rst_in = 1'b0;

        // One instruction per cycle with ex_ready held high.
        for (int i = 0; i < NUM_VECS; i++) begin
            wb_en_in       = vecs[i].wb_en;
            wb_rd_in       = vecs[i].wb_rd;
            wb_data_in     = vecs[i].wb_data;
            instr_in       = vecs[i].instr;
            instr_valid_in = 1'b1;
            ex_ready_in    = 1'b1;
            @(posedge clk_in);
            #1;
            check($sformatf("vec%0d ex_valid", i), {31'd0, ex_valid_out}, 32'd1);
            check($sformatf("vec%0d opcode", i), {25'd0, opcode_out}, {25'd0, vecs[i].opcode});
            check($sformatf("vec%0d funct3", i), {29'd0, funct3_out}, {29'd0, vecs[i].funct3});
            check($sformatf("vec%0d funct7", i), {25'd0, funct7_out}, {25'd0, vecs[i].funct7});
            check($sformatf("vec%0d rs1_value", i), rs1_value_out, vecs[i].rs1_value);
            check($sformatf("vec%0d mux_result", i), mux_result_out, vecs[i].mux_result);
            check($sformatf("vec%0d rd", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d illegal", i), {31'd0, illegal_out}, {31'd0, vecs[i].illegal});
        end

        // Drain with no valid instruction: valid drops, payload keeps last values.
        wb_en_in       = 1'b0;
        instr_valid_in = 1'b0;
        instr_in       = 32'hFFFFFFFF;
        ex_ready_in    = 1'b1;
        @(posedge clk_in);
        #1;
        check("drain ex_valid", {31'd0, ex_valid_out}, 32'd0);
        check("drain mux_result held", mux_result_out, 32'h55);
        check("drain rd held", {27'd0, rd_out}, 32'd6);

        // Stream with stalls; scoreboard checks order, freeze and ready.
        rdy_pat = 16'b1111_1011_1011_0000;  // bit n = ex_ready in cycle n
        sent    = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            rdy            = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
            ex_ready_in    = rdy;
            instr_valid_in = (sent < NUM_STREAM);
            instr_in       = (sent < NUM_STREAM) ? stream_instr(sent) : 32'h0;
            @(negedge clk_in);
            exp_valid = (sb.size() != 0);
            check($sformatf("stream c%0d ex_valid", cyc), {31'd0, ex_valid_out}, {31'd0, exp_valid});
            check($sformatf("stream c%0d instr_ready", cyc), {31'd0, instr_ready_out},
                  {31'd0, (!exp_valid || rdy)});
            if (exp_valid) begin
                check($sformatf("stream c%0d mux_result", cyc), mux_result_out, sb[0][31:0]);
                check($sformatf("stream c%0d rd", cyc), {27'd0, rd_out}, {27'd0, sb[0][36:32]});
            end
            acc = instr_valid_in && (!exp_valid || rdy);
            if (exp_valid && rdy) void'(sb.pop_front());
            if (acc) begin
                sb.push_back({5'd8 + sent[4:0], 32'h100 + sent});
                sent++;
            end
            @(posedge clk_in);
            #1;
            if (sent == NUM_STREAM && sb.size() == 0) done = 1'b1;
        end
        check("stream completed", {31'd0, done}, 32'd1);

        // Write x5 while reading it (bypass), then read it from the array.
        instr_valid_in = 1'b1;
        instr_in       = 32'h00028393;  // addi x7, x5, 0
        ex_ready_in    = 1'b1;
        wb_en_in       = 1'b1;
        wb_rd_in       = 5'd5;
        wb_data_in     = 32'h77;
        @(posedge clk_in);
        #1;
        check("x5 bypass", rs1_value_out, 32'h77);
        wb_en_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("x5 stored", rs1_value_out, 32'h77);
        check("x5 rd", {27'd0, rd_out}, 32'd7);

        // Asynchronous reset between edges, with a pending writeback that must not land.
        wb_en_in   = 1'b1;
        wb_data_in = 32'h99;
        #2;
        rst_in = 1'b1;
        #1;
        check("async reset ex_valid", {31'd0, ex_valid_out}, 32'd0);
        check("async reset rs1_value", rs1_value_out, 32'd0);
        check("async reset rd", {27'd0, rd_out}, 32'd0);
        check("async reset opcode", {25'd0, opcode_out}, 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in   = 1'b0;
        wb_en_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("post-reset ex_valid", {31'd0, ex_valid_out}, 32'd1);
        check("post-reset x5 read", rs1_value_out, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
